// File: rtl/iir_pkg.sv
// iir_pkg: shared widths, default coefficients and rounding constants for the IIR filter chain
package iir_pkg;
  localparam int DEF_IN_W = 13;
  localparam int DEF_OUT_W = 8;
  localparam int DEF_B_W = 12;
  localparam int DEF_B_FRAC = 11;
  localparam int DEF_G_W = 16;
  localparam int DEF_SHIFT = 11;
  localparam int SAT_W = 16;
  localparam logic [DEF_B_W-1:0] DEF_B_COEFF = 12'h783;
  localparam logic [DEF_G_W-1:0] DEF_G_COEFF = 16'd1;
endpackage

// File: rtl/round_sat.sv
// round_sat: round half up at SHIFT, clamp to signed OUT_W, flag the clamp
module round_sat #(
  parameter int P_W = 42,
  parameter int SHIFT = 11,
  parameter int OUT_W = 8
) (
  input  logic signed [P_W-1:0]   p,
  output logic signed [OUT_W-1:0] q,
  output logic                    ovf
);
  localparam int R_W = P_W + 1 - SHIFT;
  localparam logic signed [P_W:0] RND = (P_W+1)'(1) <<< (SHIFT - 1);
  localparam logic signed [R_W-1:0] MAXV = R_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [R_W-1:0] MINV = ~MAXV;
  logic signed [P_W:0] s;
  logic signed [R_W-1:0] r;
  logic hi, lo;
  // one extra bit keeps the rounding add from wrapping
  always_comb begin
    s = (P_W+1)'(p) + RND;
    r = R_W'(s >>> SHIFT);
    hi = r > MAXV;
    lo = r < MINV;
    ovf = hi | lo;
    q = hi ? OUT_W'(MAXV) : lo ? OUT_W'(MINV) : OUT_W'(r);
  end
endmodule

// File: rtl/iir_1st_inverse_dr.sv
// iir_1st_inverse_dr: 3-stage streaming inverse of a 1st-order IIR stage with saturation counter
module iir_1st_inverse_dr
  import iir_pkg::*;
#(
  parameter int IN_W = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int B_W = DEF_B_W,
  parameter int B_FRAC = DEF_B_FRAC,
  parameter logic [B_W-1:0] B_COEFF = DEF_B_COEFF,
  parameter int G_W = DEF_G_W,
  parameter logic [G_W-1:0] G_COEFF = DEF_G_COEFF,
  parameter int SHIFT = DEF_SHIFT
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  data_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] data_out,
  output logic [SAT_W-1:0]        sat_count
);
  localparam int D_W = IN_W + B_W + 1;
  localparam int P_W = D_W + G_W;
  localparam logic signed [B_W-1:0] B_S = B_COEFF;
  localparam logic signed [G_W-1:0] G_S = G_COEFF;
  logic signed [IN_W-1:0] y_prev, s1_y, s1_yp;
  logic signed [D_W-1:0] s2_d, d_c;
  logic signed [P_W-1:0] p_c;
  logic signed [OUT_W-1:0] q;
  logic s1_v, s2_v, en, acc, ovf;
  assign en = !out_valid | out_ready;
  assign in_ready = en & !clear;
  assign acc = in_valid & in_ready;
  assign d_c = (D_W'(s1_y) <<< B_FRAC) - D_W'(B_S) * D_W'(s1_yp);
  assign p_c = P_W'(s2_d) * P_W'(G_S);
  round_sat #(.P_W(P_W), .SHIFT(SHIFT), .OUT_W(OUT_W)) u_rs (.p(p_c), .q(q), .ovf(ovf));
  // whole pipeline moves together; history only advances on an accepted sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y_prev <= '0;
      s1_y <= '0;
      s1_yp <= '0;
      s1_v <= 1'b0;
      s2_d <= '0;
      s2_v <= 1'b0;
      out_valid <= 1'b0;
      data_out <= '0;
      sat_count <= '0;
    end else if (clear) begin
      y_prev <= '0;
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      out_valid <= 1'b0;
      sat_count <= '0;
    end else if (en) begin
      s1_v <= acc;
      if (acc) begin
        s1_y <= data_in;
        s1_yp <= y_prev;
        y_prev <= data_in;
      end
      s2_v <= s1_v;
      s2_d <= d_c;
      out_valid <= s2_v;
      if (s2_v) begin
        data_out <= q;
        if (ovf && sat_count != '1) sat_count <= sat_count + 1'b1;
      end
    end
  end
endmodule
